// File: rtl/xor_sched_pkg.sv
// -----------------------------------------------------------------------------
// xor_sched_pkg
// Shared definitions for the XOR parity scheduler: FSM state encoding,
// requester count, requester-index width and small index helpers used by
// both the arbiter and the scheduler core.
// -----------------------------------------------------------------------------
package xor_sched_pkg;

    localparam int NREQ = 3;
    localparam int ID_W = 2;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_SHIFT = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    // Next requester index modulo NREQ; the unused code 3 folds back to 0.
    function automatic logic [ID_W-1:0] rr_inc(input logic [ID_W-1:0] idx);
        case (idx)
            2'd0:    rr_inc = 2'd1;
            2'd1:    rr_inc = 2'd2;
            default: rr_inc = 2'd0;
        endcase
    endfunction

    // Requester index to one-hot grant vector; an illegal index grants nobody.
    function automatic logic [NREQ-1:0] id_onehot(input logic [ID_W-1:0] idx);
        case (idx)
            2'd0:    id_onehot = 3'b001;
            2'd1:    id_onehot = 3'b010;
            2'd2:    id_onehot = 3'b100;
            default: id_onehot = 3'b000;
        endcase
    endfunction

endpackage

// File: rtl/xor_parity_scheduler_if.sv
// -----------------------------------------------------------------------------
// xor_parity_scheduler_if
// Request/result bundle of the XOR parity scheduler.
//   req[2:0]        level requests, held until the matching grant
//   data0..data2    words to check, one per requester
//   odd             parity mode (0 even, 1 odd), sampled when the word loads
//   grant[2:0]      one-hot one-cycle pulse, requester's word captured
//   busy            scheduler not idle
//   done            one-cycle pulse, parity/done_id valid
//   parity, done_id result bit and served requester index
// master: requester side; slave: scheduler side.
// -----------------------------------------------------------------------------
interface xor_parity_scheduler_if
    import xor_sched_pkg::*;
#(
    parameter int WIDTH = 8
);
    logic [NREQ-1:0]  req;
    logic [WIDTH-1:0] data0;
    logic [WIDTH-1:0] data1;
    logic [WIDTH-1:0] data2;
    logic             odd;
    logic [NREQ-1:0]  grant;
    logic             busy;
    logic             done;
    logic             parity;
    logic [ID_W-1:0]  done_id;

    modport master (
        output req, data0, data1, data2, odd,
        input  grant, busy, done, parity, done_id
    );

    modport slave (
        input  req, data0, data1, data2, odd,
        output grant, busy, done, parity, done_id
    );
endinterface

// File: rtl/xor_parity_scheduler_arbiter.sv
// -----------------------------------------------------------------------------
// rr_arbiter3
// Combinational round-robin pick among three requesters.
//   req[2:0]    request vector
//   ptr[1:0]    highest-priority index this round (3 treated as 0)
//   winner[1:0] first asserted index searching ptr, ptr+1, ptr+2 (mod 3)
//   any         at least one request asserted
// -----------------------------------------------------------------------------
module rr_arbiter3
    import xor_sched_pkg::*;
(
    input  logic [NREQ-1:0] req,
    input  logic [ID_W-1:0] ptr,
    output logic [ID_W-1:0] winner,
    output logic            any
);
    logic [ID_W-1:0] idx0_s;
    logic [ID_W-1:0] idx1_s;
    logic [ID_W-1:0] idx2_s;

    // Priority search starting at the round-robin pointer.
    always_comb begin
        idx0_s = (ptr == 2'd3) ? 2'd0 : ptr;
        idx1_s = rr_inc(idx0_s);
        idx2_s = rr_inc(idx1_s);
        any    = |req;
        if (req[idx0_s]) begin
            winner = idx0_s;
        end else if (req[idx1_s]) begin
            winner = idx1_s;
        end else if (req[idx2_s]) begin
            winner = idx2_s;
        end else begin
            winner = 2'd0;
        end
    end
endmodule

// File: rtl/xor_parity_scheduler.sv
// -----------------------------------------------------------------------------
// xor_parity_scheduler
// One serial XOR engine shared by three requesters. A round-robin winner is
// latched in IDLE, its word is captured in LOAD, reduced one bit per cycle in
// SHIFT (WIDTH cycles) and the result is presented for one cycle in DONE.
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset
//   bus    xor_parity_scheduler_if.slave (requests, data, results)
// All outputs come straight from registers.
// -----------------------------------------------------------------------------
module xor_parity_scheduler
    import xor_sched_pkg::*;
#(
    parameter int WIDTH = 8
)
(
    input  logic                   clk,
    input  logic                   rst_n,
    xor_parity_scheduler_if.slave  bus
);
    localparam int                CNT_W    = $clog2(WIDTH + 1);
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(WIDTH - 1);

    state_t           state_r;
    state_t           state_nxt_s;
    logic [ID_W-1:0]  ptr_r;
    logic [ID_W-1:0]  winner_r;
    logic [ID_W-1:0]  arb_winner_s;
    logic             arb_any_s;
    logic [WIDTH-1:0] sel_data_s;
    logic [WIDTH-1:0] sreg_r;
    logic             acc_r;
    logic             mode_r;
    logic [CNT_W-1:0] cnt_r;
    logic [NREQ-1:0]  grant_r;
    logic             busy_r;
    logic             done_r;
    logic             parity_r;
    logic [ID_W-1:0]  done_id_r;

    rr_arbiter3 u_arb (
        .req    (bus.req),
        .ptr    (ptr_r),
        .winner (arb_winner_s),
        .any    (arb_any_s)
    );

    // Word of the latched winner; only consumed in LOAD, so later data changes are harmless.
    always_comb begin
        case (winner_r)
            2'd0:    sel_data_s = bus.data0;
            2'd1:    sel_data_s = bus.data1;
            2'd2:    sel_data_s = bus.data2;
            default: sel_data_s = {WIDTH{1'b0}};
        endcase
    end

    // FSM next-state decode.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (arb_any_s) begin
                    state_nxt_s = ST_LOAD;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_LOAD:  state_nxt_s = ST_SHIFT;
            ST_SHIFT: begin
                if (cnt_r == CNT_LAST) begin
                    state_nxt_s = ST_DONE;
                end else begin
                    state_nxt_s = ST_SHIFT;
                end
            end
            ST_DONE:  state_nxt_s = ST_IDLE;
            default:  state_nxt_s = ST_IDLE;
        endcase
    end

    // Datapath, arbitration pointer and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r   <= ST_IDLE;
            ptr_r     <= 2'd0;
            winner_r  <= 2'd0;
            sreg_r    <= {WIDTH{1'b0}};
            acc_r     <= 1'b0;
            mode_r    <= 1'b0;
            cnt_r     <= {CNT_W{1'b0}};
            grant_r   <= 3'b000;
            busy_r    <= 1'b0;
            done_r    <= 1'b0;
            parity_r  <= 1'b0;
            done_id_r <= 2'd0;
        end else begin
            state_r <= state_nxt_s;
            busy_r  <= (state_nxt_s != ST_IDLE);
            grant_r <= 3'b000;
            done_r  <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (arb_any_s) begin
                        winner_r <= arb_winner_s;
                        grant_r  <= id_onehot(arb_winner_s);
                    end
                end
                ST_LOAD: begin
                    sreg_r <= sel_data_s;
                    acc_r  <= 1'b0;
                    mode_r <= bus.odd;
                    cnt_r  <= {CNT_W{1'b0}};
                end
                ST_SHIFT: begin
                    acc_r  <= acc_r ^ sreg_r[0];
                    sreg_r <= {1'b0, sreg_r[WIDTH-1:1]};
                    cnt_r  <= cnt_r + CNT_W'(1);
                    // Result is formed on the last shift so it is registered by DONE.
                    if (cnt_r == CNT_LAST) begin
                        done_r    <= 1'b1;
                        parity_r  <= acc_r ^ sreg_r[0] ^ mode_r;
                        done_id_r <= winner_r;
                    end
                end
                ST_DONE: begin
                    ptr_r <= rr_inc(winner_r);
                end
                default: begin
                    ptr_r <= 2'd0;
                end
            endcase
        end
    end

    assign bus.grant   = grant_r;
    assign bus.busy    = busy_r;
    assign bus.done    = done_r;
    assign bus.parity  = parity_r;
    assign bus.done_id = done_id_r;

endmodule

// File: tb/tb_xor_parity_scheduler.sv
// -----------------------------------------------------------------------------
// tb_xor_parity_scheduler
// Directed bench: expected {done_id, parity} pairs are queued as requests are
// driven and popped by a monitor whenever done pulses. Grant/done timing is
// checked against the request cycle.
// -----------------------------------------------------------------------------
module tb_xor_parity_scheduler;
    import xor_sched_pkg::*;

    typedef struct packed {
        logic [1:0] id;
        logic       par;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   cyc = 0;
    int   errors = 0;
    int   checks = 0;
    int   done_cnt = 0;
    exp_t sb[$];
    exp_t mon_e;

    xor_parity_scheduler_if #(.WIDTH(8)) bus ();

    xor_parity_scheduler #(.WIDTH(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic push_exp(input logic [1:0] id, input logic par);
        exp_t e;
        e.id  = id;
        e.par = par;
        sb.push_back(e);
    endtask

    // Scoreboard monitor: every done pulse must match the oldest expectation.
    always @(negedge clk) begin
        if (bus.done === 1'b1) begin
            done_cnt++;
            chk("done_expected", 32'(sb.size() > 0), 32'd1);
            if (sb.size() > 0) begin
                mon_e = sb.pop_front();
                chk("done_id", 32'(bus.done_id), 32'(mon_e.id));
                chk("parity", 32'(bus.parity), 32'(mon_e.par));
            end
        end
    end

    task automatic check_outputs_zero(input string tag);
        chk(tag, {27'd0, bus.grant, bus.busy, bus.done, bus.parity},  32'd0);
        chk({tag, "_id"}, 32'(bus.done_id), 32'd0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check_outputs_zero("reset_outputs");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic wait_grant(input logic [2:0] exp, input int exp_cyc, input string tag);
        int n = 0;
        @(negedge clk);
        while (bus.grant === 3'b000 && n < 40) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "_grant"}, 32'(bus.grant), 32'(exp));
        chk({tag, "_grant_cycle"}, cyc, exp_cyc);
        chk({tag, "_busy"}, 32'(bus.busy), 32'd1);
        bus.req = bus.req & ~bus.grant;
    endtask

    task automatic wait_done(input int exp_cyc, input string tag, output int got);
        int n = 0;
        @(negedge clk);
        while (bus.done !== 1'b1 && n < 40) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "_done_cycle"}, cyc, exp_cyc);
        got = cyc;
    endtask

    task automatic single(input logic [2:0] r, input logic [7:0] d, input logic md,
                          input logic [1:0] id, input logic par, input string tag);
        int t;
        int got;
        @(negedge clk);
        case (id)
            2'd0:    bus.data0 = d;
            2'd1:    bus.data1 = d;
            default: bus.data2 = d;
        endcase
        bus.odd = md;
        bus.req = r;
        t = cyc;
        push_exp(id, par);
        wait_grant(r, t + 1, tag);
        wait_done(t + 10, tag, got);
    endtask

    initial begin
        int t;
        int d;
        int dc;
        bus.req   = 3'b000;
        bus.data0 = 8'h00;
        bus.data1 = 8'h00;
        bus.data2 = 8'h00;
        bus.odd   = 1'b0;

        do_reset();

        // Basic word, latency and busy drop after DONE.
        single(3'b001, 8'hA5, 1'b0, 2'd0, 1'b0, "a5_even");
        @(negedge clk);
        chk("idle_busy", 32'(bus.busy), 32'd0);
        chk("idle_done", 32'(bus.done), 32'd0);

        // Single one, even then odd mode.
        single(3'b001, 8'h01, 1'b0, 2'd0, 1'b1, "01_even");
        single(3'b001, 8'h01, 1'b1, 2'd0, 1'b0, "01_odd");

        // Three held requests from a fresh pointer: order 0,1,2, 11 cycles apart.
        do_reset();
        @(negedge clk);
        bus.data0 = 8'h07;
        bus.data1 = 8'h03;
        bus.data2 = 8'hFF;
        bus.odd   = 1'b0;
        bus.req   = 3'b111;
        t = cyc;
        push_exp(2'd0, 1'b1);
        push_exp(2'd1, 1'b0);
        push_exp(2'd2, 1'b0);
        wait_grant(3'b001, t + 1, "rr0");
        wait_done(t + 10, "rr0", d);
        wait_grant(3'b010, d + 2, "rr1");
        wait_done(d + 11, "rr1", d);
        wait_grant(3'b100, d + 2, "rr2");
        wait_done(d + 11, "rr2", d);

        // Serve requester 1, then 0 and 2 together: 2 goes first.
        single(3'b010, 8'h3C, 1'b0, 2'd1, 1'b0, "serve1");
        @(negedge clk);
        bus.data0 = 8'h80;
        bus.data2 = 8'h55;
        bus.req   = 3'b101;
        t = cyc;
        push_exp(2'd2, 1'b0);
        push_exp(2'd0, 1'b1);
        wait_grant(3'b100, t + 1, "rot2");
        wait_done(t + 10, "rot2", d);
        wait_grant(3'b001, d + 2, "rot0");
        wait_done(d + 11, "rot0", d);

        // Reset in the 4th SHIFT cycle discards the operation.
        @(negedge clk);
        bus.data0 = 8'hFF;
        bus.req   = 3'b001;
        t = cyc;
        wait_grant(3'b001, t + 1, "abort");
        repeat (4) @(negedge clk);
        dc = done_cnt;
        rst_n = 1'b0;
        #1;
        check_outputs_zero("midop_reset");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (14) @(negedge clk);
        chk("no_done_after_abort", done_cnt, dc);
        single(3'b100, 8'h01, 1'b0, 2'd2, 1'b1, "post_reset");

        // Input changes during SHIFT must not affect the captured word or mode.
        @(negedge clk);
        bus.data0 = 8'h0F;
        bus.odd   = 1'b0;
        bus.req   = 3'b001;
        t = cyc;
        push_exp(2'd0, 1'b0);
        wait_grant(3'b001, t + 1, "toggle");
        @(posedge clk);
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            bus.data0 = ~bus.data0;
            bus.odd   = ~bus.odd;
        end
        wait_done(t + 10, "toggle", d);
        bus.odd = 1'b0;

        repeat (3) @(negedge clk);
        chk("scoreboard_empty", 32'(sb.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/xor_parity_scheduler.md
XOR_PARITY_SCHEDULER -- requirements
Module: xor_parity_scheduler

Interface
REQ-001 Parameter: WIDTH, 8, data word width in bits; SHALL be >= 2.
REQ-002 Port: clk  in  1  single clock; all state updates on rising edge.
REQ-003 Port: rst_n  in  1  reset, asynchronous, active-low.
REQ-004 Port: req  in  3  request per requester k = 0..2; level, held until grant[k].
REQ-005 Port: data0, data1, data2  in  WIDTH each  word to be checked, one per requester; valid while req[k]=1.
REQ-006 Port: odd  in  1  parity mode sampled in LOAD; 0 = even, 1 = odd.
REQ-007 Port: grant  out  3  one-hot, one-cycle pulse; requester k's word captured.
REQ-008 Port: busy  out  1  high in every state except IDLE.
REQ-009 Port: done  out  1  one-cycle pulse; parity and done_id valid.
REQ-010 Port: parity  out  1  parity bit for the served word.
REQ-011 Port: done_id  out  2  index of the served requester.

Function
REQ-012 Shared serial XOR engine: one word at a time, one bit per cycle, arbitrated among 3 requesters.
REQ-013 FSM states: IDLE, LOAD, SHIFT, DONE.
REQ-014 IDLE: req != 0 -> winner latched, go to LOAD; req == 0 -> stay in IDLE.
REQ-015 Winner: round-robin; first asserted req index at or after pointer ptr, search order ptr, ptr+1, ptr+2 (mod 3).
REQ-016 LOAD, one cycle: grant[winner]=1; shift register <= data_winner; accumulator <= 0; mode <= odd; bit counter <= 0; go to SHIFT.
REQ-017 SHIFT, exactly WIDTH cycles: acc <= acc ^ sreg[0]; sreg shifts right by 1; counter increments; last cycle (counter = WIDTH-1) goes to DONE.
REQ-018 DONE, one cycle: done=1; parity = acc ^ mode; done_id = winner; ptr <= (winner+1) mod 3; go to IDLE.
REQ-019 Latency: req sampled in IDLE at edge t; grant high in cycle t+1; done high in cycle t+WIDTH+2.
REQ-020 Even mode: parity = XOR of all word bits, so the word plus parity holds an even number of ones; odd mode gives the complement.
REQ-021 Winner is fixed once latched; dropping req[winner] after IDLE does not cancel the grant or the computation.
REQ-022 Requests arriving outside IDLE are ignored until the next IDLE; req still high at IDLE is treated as a new request.
REQ-023 data*, odd and req changes during SHIFT/DONE SHALL NOT affect the result.
REQ-024 Outputs registered or decoded from state only; no combinational path from inputs to outputs.
REQ-025 Bit counter width = $clog2(WIDTH+1); no wrap beyond WIDTH.

Reset
REQ-026 rst_n=0 immediately: state=IDLE, ptr=0, acc=0, sreg=0, counter=0, mode=0, winner=0.
REQ-027 Outputs during reset: grant=0, busy=0, done=0, parity=0, done_id=0.
REQ-028 Reset mid-operation discards the operation; no done is emitted for it; arbitration restarts at ptr=0.

Structure
REQ-029 Package xor_sched_pkg holds: state enum, NREQ=3, ID_W=2.
REQ-030 Sub-module rr_arbiter3: combinational; inputs req[2:0], ptr[1:0]; outputs winner[1:0], any.

Verification (WIDTH=8; t = cycle req rises, IDLE)
REQ-031 req=001, data0=8'hA5, odd=0 -> grant=001 at t+1; done at t+10, parity=0, done_id=0.
REQ-032 req=001, data0=8'h01, odd=0 -> parity=1; repeated with odd=1 -> parity=0.
REQ-033 req=111 held until each grant, data0=8'h07, data1=8'h03, data2=8'hFF, odd=0 -> grants in order 0, 1, 2; parities 1, 0, 0; done every 11 cycles.
REQ-034 After serving requester 1, req=101 simultaneously -> requester 2 granted first, then 0.
REQ-035 rst_n=0 in the 4th SHIFT cycle -> all outputs 0 at once, no done; after release, req=100 -> grant=100.
REQ-036 data0 toggled every cycle during SHIFT after capturing 8'h0F -> parity=0, unaffected.
